// File: rtl/avr_pkg.sv
// avr_pkg: shared AVR core constants and opcode helpers.
// Used by fetch and decode.
package avr_pkg;

  localparam logic [15:0] AVR_NOP = 16'h0000;

  localparam logic [15:0] OP2_JMPCALL_MASK  = 16'hFE0C;
  localparam logic [15:0] OP2_JMPCALL_MATCH = 16'h940C;
  localparam logic [15:0] OP2_LDSSTS_MASK   = 16'hFC0F;
  localparam logic [15:0] OP2_LDSSTS_MATCH  = 16'h9000;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & OP2_JMPCALL_MASK) == OP2_JMPCALL_MATCH) ||
           ((w & OP2_LDSSTS_MASK) == OP2_LDSSTS_MATCH);
  endfunction

endpackage

// File: rtl/avr_fetch_queue_fifo.sv
// avr_fetch_queue_fifo: circular buffer of fetched words + PCs.
// Pops one or two entries; exposes head and head+1.
module avr_fetch_queue_fifo
  import avr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              push,
  input  logic [15:0]       push_word,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop1,
  input  logic              pop2,
  output logic [15:0]       head_word,
  output logic [ADDR_W-1:0] head_pc,
  output logic [15:0]       next_word,
  output logic [CW-1:0]     count
);

  logic [15:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [CW-1:0]     pop_n;

  // Number of entries leaving the head this cycle.
  always_comb begin
    pop_n = '0;
    unique case (1'b1)
      pop2:    pop_n = CW'(2);
      pop1:    pop_n = CW'(1);
      default: pop_n = '0;
    endcase
  end

  assign rd_nxt    = rd_ptr + PW'(1);
  assign head_word = word_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];
  assign next_word = word_q[rd_nxt];

  // Storage array; contents are don't-care until counted valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      word_q[wr_ptr] <= push_word;
      pc_q[wr_ptr]   <= push_pc;
    end
  end

  // Pointers and occupancy; flush empties the queue at once.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count  <= count + CW'(push) - pop_n;
    end
  end

endmodule

// File: rtl/avr_fetch_queue.sv
// avr_fetch_queue: program-memory prefetch queue for decode.
// Presents complete 1- or 2-word instructions; flushes on redirect.
module avr_fetch_queue
  import avr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              pm_rd,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [15:0]       pm_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [15:0]       instr_ext,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_two,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic              inflight;
  logic              kill;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [15:0]       head_word;
  logic [ADDR_W-1:0] head_pc;
  logic [15:0]       next_word;
  logic              head_two;
  logic              push;
  logic              take;

  assign occ   = {1'b0, count} + (CW+1)'(inflight);
  assign pm_rd = (occ < (CW+1)'(DEPTH)) && !redirect && !RST;
  assign push  = inflight && !kill && !redirect;

  assign head_two    = is_two_word(head_word);
  assign instr_valid = head_two ? (count >= CW'(2))
                                : (count >= CW'(1));
  assign take        = instr_valid && instr_ready && !redirect;

  avr_fetch_queue_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redirect),
    .push      (push),
    .push_word (pm_data),
    .push_pc   (rd_pc),
    .pop1      (take && !head_two),
    .pop2      (take && head_two),
    .head_word (head_word),
    .head_pc   (head_pc),
    .next_word (next_word),
    .count     (count)
  );

  // Fetch pointer, outstanding-read tracking and return kill.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc <= '0;
      rd_pc    <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= pm_rd;
      kill     <= redirect && inflight;
      if (pm_rd) rd_pc <= fetch_pc;
      if (redirect)   fetch_pc <= redirect_pc;
      else if (pm_rd) fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // Head presentation, zeroed unless a full instruction is ready.
  always_comb begin
    pm_addr   = pm_rd ? fetch_pc : '0;
    instr     = AVR_NOP;
    instr_ext = 16'h0000;
    instr_pc  = '0;
    instr_two = 1'b0;
    if (instr_valid) begin
      instr     = head_word;
      instr_pc  = head_pc;
      instr_two = head_two;
      if (head_two) instr_ext = next_word;
    end
  end

endmodule

// File: tb/tb_avr_fetch_queue.sv
// tb_avr_fetch_queue: directed + random checks of the prefetch queue
// against an instruction-stream reference model.
module tb_avr_fetch_queue;

  logic        CLK;
  logic        RST;
  logic        pm_rd;
  logic [15:0] pm_addr;
  logic [15:0] pm_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic [15:0] instr_pc;
  logic        instr_two;
  logic        instr_valid;
  logic        instr_ready;

  logic [15:0] mem [65536];
  logic [15:0] exp_pc;
  logic [15:0] exp_fetch;
  int          n_chk;
  int          n_fail;

  avr_fetch_queue #(.DEPTH(4), .ADDR_W(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pm_rd       (pm_rd),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_pc    (instr_pc),
    .instr_two   (instr_two),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous program memory; garbage when no read was issued.
  always @(posedge CLK) begin
    if (pm_rd) pm_data <= mem[pm_addr];
    else       pm_data <= 16'($urandom);
  end

  function automatic logic two_word(input logic [15:0] w);
    casez (w)
      16'b1001_010?_????_11??: return 1'b1;
      16'b1001_00??_????_0000: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cyc(input logic r, input logic rd,
                     input logic [15:0] rp, input logic rdy);
    logic [15:0] w;
    logic [15:0] a1;
    logic        t;
    RST = r;
    redirect = rd;
    redirect_pc = rp;
    instr_ready = rdy;
    #1;
    if (r || rd) check("no_rd", pm_rd, 0);
    if (pm_rd) begin
      check("pm_addr", pm_addr, exp_fetch);
      exp_fetch = exp_fetch + 16'd1;
    end
    if (!instr_valid)
      check("idle_out", {instr, instr_ext, instr_pc, instr_two}, 0);
    if (!r && !rd && instr_valid && rdy) begin
      w  = mem[exp_pc];
      t  = two_word(w);
      a1 = exp_pc + 16'd1;
      check("pc", instr_pc, exp_pc);
      check("instr", instr, w);
      check("two", instr_two, t);
      check("ext", instr_ext, t ? mem[a1] : 16'h0);
      exp_pc = exp_pc + (t ? 16'd2 : 16'd1);
    end
    if (r) begin
      exp_pc = 0;
      exp_fetch = 0;
    end else if (rd) begin
      exp_pc = rp;
      exp_fetch = rp;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 1);
      tick();
    end
  endtask

  initial begin
    logic [15:0] addrs [3];
    int reads;
    int n;
    logic r;
    logic rd;
    logic rdy;
    logic [15:0] rp;
    int sel;
    n_chk = 0;
    n_fail = 0;
    exp_pc = 0;
    exp_fetch = 0;
    RST = 1'b1;
    redirect = 1'b0;
    redirect_pc = 0;
    instr_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 16'h1000);
    @(negedge CLK);
    do_reset();
    cyc(1, 0, 0, 1);
    check("rst_out_a", {pm_rd, pm_addr, instr, instr_valid}, 0);
    check("rst_out_b", {instr_ext, instr_pc, instr_two}, 0);
    tick();

    // 1: reset release latency and gapless streaming
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, 1);
      if (c == 0) check("t1_rd0", {pm_rd, pm_addr}, {1'b1, 16'h0});
      if (c < 2) check("t1_lat", instr_valid, 0);
      if (c == 2)
        check("t1_first", {instr_valid, instr, instr_pc},
              {1'b1, 16'h1000, 16'h0000});
      if (c >= 2) check("t1_nogap", instr_valid, 1);
      tick();
    end

    // 2: stalled decode fills queue with exactly DEPTH reads
    do_reset();
    reads = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 0, 0, 0);
      reads += int'(pm_rd);
      if (c >= 4) check("t2_full", pm_rd, 0);
      tick();
    end
    check("t2_reads", reads, 4);
    for (int c = 0; c < 8; c++) begin
      cyc(0, 0, 0, 1);
      if (c == 0) check("t2_head", {instr_valid, instr_pc}, {1'b1, 16'h0});
      tick();
    end

    // 3: two-word JMP at pc 5
    mem[5] = 16'h940C;
    mem[6] = 16'h0123;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, 1);
      if (c == 7) check("t3_half", instr_valid, 0);
      if (c == 8)
        check("t3_jmp", {instr_valid, instr_two, instr, instr_ext, instr_pc},
              {1'b1, 1'b1, 16'h940C, 16'h0123, 16'h0005});
      if (c == 9) check("t3_after", {instr_valid, instr_pc}, {1'b1, 16'h7});
      tick();
    end

    // 4: redirect with a read in flight
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(0, c == 5, 16'h0040, 1);
      if (c == 6)
        check("t4_refetch", {pm_rd, pm_addr, instr_valid},
              {1'b1, 16'h0040, 1'b0});
      if (c == 7) check("t4_gap", instr_valid, 0);
      if (c == 8) check("t4_pc", {instr_valid, instr_pc}, {1'b1, 16'h0040});
      tick();
    end

    // 5: address wrap through 0xFFFF
    n = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, c == 0, 16'hFFFE, 1);
      if (pm_rd && n < 3) begin
        addrs[n] = pm_addr;
        n++;
      end
      if (c == 3) check("t5_pc0", {instr_valid, instr_pc}, {1'b1, 16'hFFFE});
      if (c == 4) check("t5_pc1", {instr_valid, instr_pc}, {1'b1, 16'hFFFF});
      if (c == 5) check("t5_pc2", {instr_valid, instr_pc}, {1'b1, 16'h0000});
      tick();
    end
    check("t5_n", n, 3);
    check("t5_a", {addrs[0], addrs[1], addrs[2]},
          {16'hFFFE, 16'hFFFF, 16'h0000});

    // 6: reset in the middle of operation
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc(0, 0, 0, 0);
      if (c == 4) check("t6_q", {instr_valid, instr_pc}, {1'b1, 16'h0});
      tick();
    end
    cyc(1, 0, 0, 1);
    tick();
    cyc(1, 0, 0, 1);
    check("t6_out_a", {pm_rd, pm_addr, instr, instr_valid}, 0);
    check("t6_out_b", {instr_ext, instr_pc, instr_two}, 0);
    tick();
    cyc(0, 0, 0, 1);
    check("t6_rd0", {pm_rd, pm_addr}, {1'b1, 16'h0});
    tick();
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, 0, 1);
      tick();
    end

    // random: mixed opcodes, stalls, redirects and resets
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 65536; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      mem[i] = 16'h940C | (16'($urandom) & 16'h01F3);
      else if (sel == 1) mem[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
      else               mem[i] = 16'($urandom);
    end
    tick();
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 29) == 0);
      rp  = 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, rd, rp, rdy);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
